// File: rtl/soc_system_pll_pkg.sv
// Shared state encoding, default tuning constants and sizing helpers for the
// system PLL lock supervisor.
package soc_system_pll_pkg;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_STABLE_CYCLES       = 1024;
    localparam int DEF_MAX_RETRIES         = 3;

    localparam int RETRY_W = 2;
    localparam int LOST_W  = 8;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One counter serves every timed state, so it must hold the largest limit.
    function automatic int cnt_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c) + 1);
    endfunction

endpackage

// File: rtl/soc_system_sync2.sv
// Two-flop synchronizer for slow asynchronous status inputs; clears to zero
// under synchronous reset.
module soc_system_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/soc_system_pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock with bounded retries, and holds
// the outclk-domain logic in reset until the lock has settled.
module soc_system_pll_lock_supervisor
    import soc_system_pll_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              locked,
    output logic              pll_rst,
    output logic              stream_rst,
    output logic              ready,
    output logic              fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [LOST_W-1:0]  lock_lost_count
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOST_W-1:0]  lost_q, lost_d;

    logic pll_rst_q;
    logic stream_rst_q;
    logic ready_q;
    logic fail_q;

    logic locked_s;

    soc_system_sync2 #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        unique case (state_q)
            PLL_RESET: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_LOCK: begin
                // A lock seen on the timeout cycle wins over the timeout.
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (int'(retry_q) < MAX_RETRIES) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = PLL_RESET;
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RESET;
                    cnt_d   = '0;
                    if (lost_q != '1) begin
                        lost_d = lost_q + LOST_W'(1);
                    end
                end
            end

            FAIL: begin
                state_d = FAIL;
            end

            default: begin
                state_d = PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // register while still coming straight from flops.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= PLL_RESET;
            cnt_q        <= '0;
            retry_q      <= '0;
            lost_q       <= '0;
            pll_rst_q    <= 1'b1;
            stream_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            pll_rst_q    <= (state_d == PLL_RESET) || (state_d == FAIL);
            stream_rst_q <= (state_d != RUN);
            ready_q      <= (state_d == RUN);
            fail_q       <= (state_d == FAIL);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign stream_rst      = stream_rst_q;
    assign ready           = ready_q;
    assign fail            = fail_q;
    assign retry_count     = retry_q;
    assign lock_lost_count = lost_q;

endmodule
